// File: rtl/card_deck_shuffler.sv
// card_deck_shuffler: builds a Fisher-Yates shuffled deck of card pair IDs.
// Randomness comes from a free-running LFSR, so the layout depends on click timing.
module card_deck_shuffler #(
  parameter int          MAX_CARDS = 24,
  parameter int          NUM_W     = 5,
  parameter int          ID_W      = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_of_cards_i,
  input  logic [NUM_W-1:0] rd_addr_i,
  output logic [ID_W-1:0]  rd_data_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic             done_o,
  output logic             err_o
);
  localparam logic [2:0] IDLE = 3'd0, LATCH = 3'd1, FILL = 3'd2, PICK = 3'd3, SWAP = 3'd4, FINISH = 3'd5;
  localparam logic [NUM_W-1:0] MAX_N = NUM_W'(MAX_CARDS);
  logic [2:0] state_q, state_d;
  logic [NUM_W-1:0] n_q, n_d, i_q, i_d, j_q, j_d, j_cand;
  logic [15:0] lfsr_q, lfsr_d;
  logic ready_q, ready_d, err_q, err_d, n_ok;
  logic [ID_W-1:0] deck_q [MAX_CARDS];
  assign j_cand = lfsr_q[NUM_W-1:0];
  assign n_ok = !num_of_cards_i[0] && num_of_cards_i >= NUM_W'(2) && num_of_cards_i <= MAX_N;
  assign rd_data_o = (rd_addr_i < MAX_N) ? deck_q[rd_addr_i] : '0;
  assign busy_o = (state_q != IDLE) && (state_q != FINISH);
  assign done_o = state_q == FINISH;
  assign ready_o = ready_q;
  assign err_o = err_q;
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
    state_d = state_q;
    n_d = n_q;
    i_d = i_q;
    j_d = j_q;
    ready_d = ready_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start_i ? LATCH : IDLE;
        ready_d = start_i ? 1'b0 : ready_q;
      end
      LATCH: begin
        n_d = num_of_cards_i;
        i_d = '0;
        state_d = n_ok ? FILL : IDLE;
        err_d = !n_ok;
      end
      FILL: begin
        state_d = (i_q == n_q - 1'b1) ? PICK : FILL;
        i_d = (i_q == n_q - 1'b1) ? i_q : i_q + 1'b1;
      end
      PICK: begin
        state_d = (j_cand <= i_q) ? SWAP : PICK;
        j_d = j_cand;
      end
      SWAP: begin
        i_d = i_q - 1'b1;
        state_d = (i_q == NUM_W'(1)) ? FINISH : PICK;
        ready_d = i_q == NUM_W'(1);
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      i_q <= '0;
      j_q <= '0;
      lfsr_q <= LFSR_SEED;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      for (int k = 0; k < MAX_CARDS; k++) deck_q[k] <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      i_q <= i_d;
      j_q <= j_d;
      lfsr_q <= lfsr_d;
      ready_q <= ready_d;
      err_q <= err_d;
      // a valid request clears the whole deck so entries beyond N read as 0
      if (state_q == LATCH && n_ok)
        for (int k = 0; k < MAX_CARDS; k++) deck_q[k] <= '0;
      if (state_q == FILL) deck_q[i_q] <= ID_W'(i_q >> 1);
      if (state_q == SWAP) begin
        deck_q[i_q] <= deck_q[j_q];
        deck_q[j_q] <= deck_q[i_q];
      end
    end
  end
endmodule

// File: doc/card_deck_shuffler.md
Name: card_deck_shuffler

Overview:
- Sits directly downstream of the difficulty-selection screen.
- Consumes its "difficulty button pressed" strobe and registered card count, then builds a shuffled deck of card pair IDs in an internal register array.
- Shuffle is Fisher-Yates, driven by a free-running LFSR, so the layout depends on when the user clicks.
- The board renderer and game logic read the deck via a combinational read port once `ready` is high.

Parameters:
- MAX_CARDS, 24, deck capacity (even).
- NUM_W, 5, width of card count and card indices (2^NUM_W > MAX_CARDS).
- ID_W, 4, width of pair ID (2^ID_W >= MAX_CARDS/2).
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  shuffle request, connected to difficulty_butts_pressed (one-cycle strobe)
- num_of_cards  in  NUM_W  requested deck size; valid one cycle after start
- rd_addr  in  NUM_W  deck read index
- rd_data  out  ID_W  pair ID at rd_addr, combinational
- busy  out  1  high from start acceptance until done/err
- ready  out  1  deck valid
- done  out  1  one-cycle pulse, shuffle complete
- err  out  1  one-cycle pulse, invalid num_of_cards

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high. All state is updated on posedge clk.
- Reset state:
  - FSM is IDLE.
  - busy=0, ready=0, done=0, err=0.
  - Deck array all 0; count register 0; LFSR=LFSR_SEED.
  - Reset mid-operation aborts immediately and yields the same state. No partial deck is ever flagged ready.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Advances every cycle in every state except during reset.
- FSM states: IDLE, LATCH, FILL, PICK, SWAP, FINISH.
- IDLE:
  - start=1 → LATCH; busy=1, ready=0.
  - start=0 → remain.
- LATCH:
  - Samples num_of_cards into N. The upstream register updates one cycle after the strobe, so the value on the start cycle must not be used.
  - N valid (even, 2..MAX_CARDS) → FILL; index i=0.
  - Otherwise → IDLE with err=1 for one cycle, busy=0, ready=0. Deck contents are unchanged.
- FILL:
  - Each cycle writes deck[i]=i>>1, then i++.
  - After writing deck[N-1]: i=N-1 → PICK.
  - Takes N cycles.
  - Entries ≥N are written 0 at the start of FILL (cleared in the same pass or in parallel).
- PICK:
  - Candidate j = LFSR[NUM_W-1:0].
  - j ≤ i → latch j, go to SWAP.
  - j > i → reject and stay; the LFSR has advanced, so the next cycle retries.
  - No cycle bound; the expected count is small.
- SWAP:
  - Exchanges deck[i] and deck[j] in one cycle. j==i leaves the deck unchanged.
  - Then i--. If the new i==0 → FINISH, else → PICK.
- FINISH:
  - done=1 for one cycle; ready=1 (held); busy=0; → IDLE.
- start handling:
  - start while busy (LATCH..FINISH) is ignored.
  - start in the same cycle FINISH → IDLE is also ignored; it is accepted only in IDLE.
- Latency for valid N: 1 (LATCH) + N (FILL) + Σ(pick tries) + (N-1) swaps + 1 (FINISH) cycles from the cycle after start.
- rd_data:
  - rd_data = deck[rd_addr] when rd_addr < MAX_CARDS, else 0.
  - Always readable; meaningful only when ready=1.
  - Reads during busy return in-progress values.
- Deck invariant on done: for every k in 0..N/2-1, ID k appears exactly twice in deck[0..N-1], and deck[N..MAX_CARDS-1]=0.

Test Plan:
- Reset, then idle → busy=0, ready=0, done=0, err=0; rd_data=0 for addr 0..23; after 100 cycles the LFSR has left 16'hACE1.
- start pulse, num_of_cards=12 updated the following cycle → done fires once; ready=1; deck[0..11] holds IDs 0..5 exactly twice each; deck[12..23]=0; measured latency ≥ 1+12+11+1=25 cycles.
- num_of_cards=2 → deck[0..1] is {0,0}; exactly one SWAP executes; done asserted.
- num_of_cards=7, then 0, then 26 → err pulses once per request; done never fires; ready stays at its previous value (0 after reset); deck unchanged.
- Repeated start pulses during busy → exactly one done. A second valid request after done with num=24 → ready drops on acceptance, then reasserts with IDs 0..11 twice each.
- Assert rst during the PICK state of a 24-card shuffle → next cycle busy=0, ready=0, deck all 0. A subsequent start with num=16 completes correctly.
